// File: rtl/viterbi_decoder.sv
`default_nettype none
// ============================================================================
// viterbi_decoder : hard-decision K=7 rate-1/2 (171o,133o) Viterbi decoder,
//                   64-state parallel ACS with register-exchange survivors
// Revision 1.0
// ============================================================================
module viterbi_decoder #(
  parameter int TB  = 32,
  parameter int PMW = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enb,
  input  logic Viterbi_Decoder1_in_0,
  input  logic Viterbi_Decoder1_in_1,
  output logic decoded,
  output logic decode_valid
);

  localparam int             NS      = 64;
  localparam int             CW      = $clog2(TB + 1);
  localparam logic [PMW-1:0] PM_MAX  = {PMW{1'b1}};
  localparam logic [PMW-1:0] PM_INIT = {{(PMW-1){1'b0}}, 1'b1} << (PMW-2);

  logic [PMW-1:0] pm        [NS];
  logic [TB-1:0]  path      [NS];
  logic [PMW-1:0] pm_next   [NS];
  logic [TB-1:0]  path_next [NS];
  logic [PMW-1:0] pm_min;
  logic [5:0]     best;
  logic [CW-1:0]  count;
  logic [1:0]     rx;

  assign rx = {Viterbi_Decoder1_in_0, Viterbi_Decoder1_in_1};

  // Hamming distance between the received pair and the pair emitted for register r.
  function automatic logic [1:0] bm(input logic [6:0] r, input logic [1:0] rcv);
    logic [1:0] d;
    d = {^(r & 7'b1111001), ^(r & 7'b1011011)} ^ rcv;
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

  // Adjacent-pair reduction tree keeps the left operand on ties, so the lowest index wins.
  always_comb begin : best_search
    logic [PMW-1:0] tpm  [NS];
    logic [5:0]     tidx [NS];
    for (int s = 0; s < NS; s++) begin
      tpm[s]  = pm[s];
      tidx[s] = 6'(s);
    end
    for (int lv = 1; lv <= 6; lv++) begin
      for (int s = 0; s < (NS >> lv); s++) begin
        if (tpm[2*s+1] < tpm[2*s]) begin
          tpm[s]  = tpm[2*s+1];
          tidx[s] = tidx[2*s+1];
        end else begin
          tpm[s]  = tpm[2*s];
          tidx[s] = tidx[2*s];
        end
      end
    end
    pm_min = tpm[0];
    best   = tidx[0];
  end

  always_comb begin : acs
    logic [5:0]     st, p0, p1;
    logic [PMW+1:0] c0, c1, win;
    logic           sel;
    st  = '0;
    p0  = '0;
    p1  = '0;
    c0  = '0;
    c1  = '0;
    win = '0;
    sel = 1'b0;
    for (int t = 0; t < NS; t++) begin
      st  = 6'(t);
      p0  = {st[4:0], 1'b0};
      p1  = {st[4:0], 1'b1};
      c0  = (PMW+2)'(pm[p0]) + (PMW+2)'(bm({st[5], p0}, rx));
      c1  = (PMW+2)'(pm[p1]) + (PMW+2)'(bm({st[5], p1}, rx));
      sel = (c1 < c0);
      // pm_min never exceeds either candidate, so the subtraction cannot wrap.
      win = (sel ? c1 : c0) - (PMW+2)'(pm_min);
      pm_next[t]   = (win > (PMW+2)'(PM_MAX)) ? PM_MAX : win[PMW-1:0];
      path_next[t] = {path[sel ? p1 : p0][TB-2:0], st[5]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NS; s++) begin
        pm[s]   <= (s == 0) ? {PMW{1'b0}} : PM_INIT;
        path[s] <= '0;
      end
      count        <= '0;
      decoded      <= 1'b0;
      decode_valid <= 1'b0;
    end else if (enb) begin
      for (int s = 0; s < NS; s++) begin
        pm[s]   <= pm_next[s];
        path[s] <= path_next[s];
      end
      decoded <= path[best][TB-1];
      if (count != CW'(TB)) begin
        count <= count + CW'(1);
      end
      if (count == CW'(TB)) begin
        decode_valid <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_viterbi_decoder.sv
`default_nettype none
// ============================================================================
// tb_viterbi_decoder : directed and encoded-stream bench for viterbi_decoder
// Revision 1.0
// ============================================================================
module tb_viterbi_decoder;

  localparam int TB = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic enb   = 1'b0;
  logic in0   = 1'b0;
  logic in1   = 1'b0;
  logic decoded;
  logic decode_valid;

  int   total = 0;
  int   bad   = 0;
  logic [5:0] enc_s = '0;
  bit   info [0:1023];

  always #5 clk = ~clk;

  viterbi_decoder #(.TB(TB), .PMW(8)) dut (
    .clk                  (clk),
    .reset                (reset),
    .enb                  (enb),
    .Viterbi_Decoder1_in_0(in0),
    .Viterbi_Decoder1_in_1(in1),
    .decoded              (decoded),
    .decode_valid         (decode_valid)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required summary");
    $fatal(1, "watchdog");
  end

  task automatic clock_pair(input logic e, input logic a, input logic b);
    enb = e;
    in0 = a;
    in1 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic encode(input logic u, output logic a, output logic b);
    logic [6:0] r;
    r     = {u, enc_s};
    a     = ^(r & 7'b1111001);
    b     = ^(r & 7'b1011011);
    enc_s = r[6:1];
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    enb   = 1'b0;
    in0   = 1'b0;
    in1   = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    enc_s = '0;
  endtask

  // Encodes random info bits, optionally corrupts/gaps them, and tallies disagreements.
  task automatic run_stream(input int n, input int flip_every, input int flip_at,
                            input int burst_at, input bit toggle,
                            input int win_lo, input int win_hi,
                            output int mism, output int vbad, output int hold_bad);
    logic a, b, u, d_hold, v_hold;
    mism     = 0;
    vbad     = 0;
    hold_bad = 0;
    for (int k = 0; k < n; k++) begin
      u       = 1'($urandom_range(0, 1));
      info[k] = u;
      encode(u, a, b);
      if (flip_every > 0 && (k % flip_every) == flip_every - 1) begin
        if (((k / flip_every) % 2) == 0) a = ~a;
        else                             b = ~b;
      end
      if (k == flip_at) a = ~a;
      if (burst_at >= 0 && k >= burst_at && k < burst_at + 4) a = ~a;
      clock_pair(1'b1, a, b);
      if (decode_valid !== (k >= TB)) vbad++;
      if (k >= TB && decoded !== info[k-TB] && !((k - TB) >= win_lo && (k - TB) <= win_hi))
        mism++;
      if (toggle) begin
        d_hold = decoded;
        v_hold = decode_valid;
        clock_pair(1'b0, ~a, 1'($urandom_range(0, 1)));
        if (decoded !== d_hold || decode_valid !== v_hold) hold_bad++;
      end
    end
  endtask

  task automatic test_reset();
    int moved;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (decoded !== 1'b0) begin
      bad++;
      $display("FAIL reset_decoded: got %b, required 0", decoded);
    end
    total++;
    if (decode_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid: got %b, required 0", decode_valid);
    end
    #2;
    reset = 1'b1;
    moved = 0;
    for (int i = 0; i < 5; i++) begin
      clock_pair(1'b0, 1'b1, 1'b1);
      if (decoded !== 1'b0 || decode_valid !== 1'b0) moved++;
    end
    total++;
    if (moved !== 0) begin
      bad++;
      $display("FAIL idle_after_reset: outputs changed %0d times, required 0", moved);
    end
  endtask

  task automatic test_all_zero();
    int nz, rise, drop;
    do_reset();
    nz   = 0;
    rise = -1;
    drop = 0;
    for (int k = 0; k < 100; k++) begin
      clock_pair(1'b1, 1'b0, 1'b0);
      if (decoded !== 1'b0) nz++;
      if (decode_valid === 1'b1 && rise < 0) rise = k;
      if (rise >= 0 && decode_valid !== 1'b1) drop++;
    end
    total++;
    if (nz !== 0) begin
      bad++;
      $display("FAIL zero_decoded: %0d nonzero outputs, required 0", nz);
    end
    total++;
    if (rise !== TB) begin
      bad++;
      $display("FAIL valid_rise: rose at pair %0d, required %0d", rise, TB);
    end
    total++;
    if (drop !== 0) begin
      bad++;
      $display("FAIL valid_sticky: dropped %0d times, required 0", drop);
    end
  endtask

  // Impulse response of (171,133): pairs {in0,in1} = 11 10 11 11 00 01 11.
  task automatic test_impulse();
    logic [1:0] imp [7];
    logic [1:0] pr;
    int errs;
    logic at_tb;
    imp = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};
    do_reset();
    errs  = 0;
    at_tb = 1'b0;
    for (int k = 0; k < TB + 20; k++) begin
      pr = (k < 7) ? imp[k] : 2'b00;
      clock_pair(1'b1, pr[1], pr[0]);
      if (k == TB) at_tb = decoded;
      if (decoded !== (k == TB)) errs++;
    end
    total++;
    if (at_tb !== 1'b1) begin
      bad++;
      $display("FAIL impulse_bit: got %b at pair %0d, required 1", at_tb, TB);
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL impulse_stream: %0d wrong outputs, required 0", errs);
    end
  endtask

  task automatic test_random();
    int m, v, h;
    do_reset();
    run_stream(1000, 0, -1, -1, 1'b0, -1, -1, m, v, h);
    total++;
    if (m !== 0) begin
      bad++;
      $display("FAIL random_decode: %0d mismatches, required 0", m);
    end
    total++;
    if (v !== 0) begin
      bad++;
      $display("FAIL random_valid: %0d wrong valid samples, required 0", v);
    end
  endtask

  task automatic test_single_error();
    int m, v, h;
    do_reset();
    run_stream(300, 0, 50, -1, 1'b0, -1, -1, m, v, h);
    total++;
    if (m !== 0) begin
      bad++;
      $display("FAIL single_error: %0d mismatches, required 0", m);
    end
  endtask

  task automatic test_sparse_errors();
    int m, v, h;
    do_reset();
    run_stream(1000, 20, -1, -1, 1'b0, -1, -1, m, v, h);
    total++;
    if (m !== 0) begin
      bad++;
      $display("FAIL sparse_errors: %0d mismatches, required 0", m);
    end
  endtask

  task automatic test_burst();
    int m, v, h;
    do_reset();
    run_stream(400, 0, -1, 200, 1'b0, 180, 240, m, v, h);
    total++;
    if (m !== 0) begin
      bad++;
      $display("FAIL burst_confined: %0d mismatches outside window, required 0", m);
    end
  endtask

  task automatic test_enb_toggle();
    int m, v, h;
    do_reset();
    run_stream(500, 0, -1, -1, 1'b1, -1, -1, m, v, h);
    total++;
    if (m !== 0) begin
      bad++;
      $display("FAIL toggle_decode: %0d mismatches, required 0", m);
    end
    total++;
    if (h !== 0) begin
      bad++;
      $display("FAIL toggle_hold: %0d output changes while disabled, required 0", h);
    end
  endtask

  task automatic test_reset_midstream();
    int m, v, h;
    logic v_before;
    do_reset();
    run_stream(60, 0, -1, -1, 1'b0, -1, -1, m, v, h);
    v_before = decode_valid;
    total++;
    if (v_before !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_valid: got %b, required 1", v_before);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (decoded !== 1'b0 || decode_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got decoded=%b valid=%b, required 0/0", decoded, decode_valid);
    end
    @(posedge clk);
    #3;
    reset = 1'b1;
    enc_s = '0;
    run_stream(300, 0, -1, -1, 1'b0, -1, -1, m, v, h);
    total++;
    if (m !== 0) begin
      bad++;
      $display("FAIL restart_decode: %0d mismatches, required 0", m);
    end
    total++;
    if (v !== 0) begin
      bad++;
      $display("FAIL restart_valid: %0d wrong valid samples, required 0", v);
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_impulse();
    test_random();
    test_single_error();
    test_sparse_errors();
    test_burst();
    test_enb_toggle();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
